// File: rtl/tuss_spi_master.sv
// tuss_spi_master: 16-bit mode-1 (CPOL=0, CPHA=1) SPI master for the TUSS4470 with optional odd-parity insert.
// Latency: done pulses 33*CLK_DIV gclk cycles after the accepted tx_en edge; busy lasts 34*CLK_DIV cycles.
// Backpressure: none; tx_en rising edges seen while busy are dropped, never queued.
module tuss_spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int AUTO_PARITY = 1
) (
  input  logic        gclk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic [15:0] tx_data,
  input  logic        miso,
  output logic [15:0] spi_data_out,
  output logic        done,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Divider wraps every CLK_DIV cycles; each wrap is one SCLK half-period boundary.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  state_t      state_d;
  logic        tx_en_q;
  logic        start;
  logic [7:0]  div_cnt;
  logic        tick;
  logic [3:0]  bit_cnt;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic [15:0] frame_in;

  // One-cycle action strobes decoded by the FSM.
  logic        load;
  logic        rise_en;
  logic        fall_en;
  logic        end_en;
  logic        finish;

  assign start = tx_en & ~tx_en_q;
  assign tick  = (state != IDLE) && (div_cnt == DIV_LAST);

  // Build the outgoing frame; parity makes the whole 16-bit word carry an odd number of ones.
  always_comb begin
    frame_in = tx_data;
    if (AUTO_PARITY != 0) begin
      frame_in[8] = ~^{tx_data[15:9], tx_data[7:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state and per-tick action strobes.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    rise_en = 1'b0;
    fall_en = 1'b0;
    end_en  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        // First tick after the setup half-period is the rising edge of bit 0.
        if (tick) begin
          state_d = SHIFT;
          rise_en = 1'b1;
        end
      end
      SHIFT: begin
        // sclk alternates on each tick; low means the next tick is a rising edge.
        if (tick) begin
          if (!sclk) begin
            rise_en = 1'b1;
          end else begin
            fall_en = 1'b1;
            if (bit_cnt == 4'd15) begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          end_en  = 1'b1;
        end
      end
      GAP: begin
        // Edges arriving on this final tick are ignored because IDLE is only entered now.
        if (tick) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // tx_en history; resets high so a level held through reset never counts as an edge.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      tx_en_q <= 1'b1;
    end else begin
      tx_en_q <= tx_en;
    end
  end

  // Half-period divider: idles at zero, restarts on every tick.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      div_cnt <= 8'd0;
    end else if ((state == IDLE) || tick) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Bit counter advances on each falling edge.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 4'd0;
    end else if (load) begin
      bit_cnt <= 4'd0;
    end else if (fall_en) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Transmit shifter: captured at the start edge so later tx_data changes cannot leak in.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      tx_sr <= 16'h0000;
    end else if (load) begin
      tx_sr <= frame_in;
    end else if (rise_en) begin
      tx_sr <= {tx_sr[14:0], 1'b0};
    end
  end

  // Receive shifter: samples miso on each falling edge, MSB first.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      rx_sr <= 16'h0000;
    end else if (load) begin
      rx_sr <= 16'h0000;
    end else if (fall_en) begin
      rx_sr <= {rx_sr[14:0], miso};
    end
  end

  // SPI pins: mosi only moves together with a rising sclk or at frame end.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      cs_n <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
    end else begin
      if (load) begin
        cs_n <= 1'b0;
        sclk <= 1'b0;
        mosi <= 1'b0;
      end else if (rise_en) begin
        sclk <= 1'b1;
        mosi <= tx_sr[15];
      end else if (fall_en) begin
        sclk <= 1'b0;
      end else if (end_en) begin
        cs_n <= 1'b1;
        mosi <= 1'b0;
      end
    end
  end

  // Status outputs: busy spans frame plus gap, done marks the single update of spi_data_out.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      spi_data_out <= 16'h0000;
    end else begin
      done <= end_en;
      if (load) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (end_en) begin
        spi_data_out <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_tuss_spi_master.sv
// tb_tuss_spi_master: scoreboard bench for two configurations (CLK_DIV=4 with parity, CLK_DIV=2 verbatim).
// Latency: expectations are timed against the accepted tx_en edge of each frame.
// Backpressure: frames are issued only when the bench intends them to be accepted or dropped.
module tb_tuss_spi_master;

  logic        gclk = 1'b0;
  logic        rst  = 1'b1;
  logic [1:0]  tx_en;
  logic [1:0]  miso;
  logic [1:0]  done;
  logic [1:0]  busy;
  logic [1:0]  cs_n;
  logic [1:0]  sclk;
  logic [1:0]  mosi;
  logic [15:0] tx_data [2];
  logic [15:0] spi_out [2];

  int dv  [2] = '{4, 2};
  bit apv [2] = '{1'b1, 1'b0};

  typedef struct {
    int          inst;
    logic [15:0] mosi;
    logic [15:0] rx;
  } exp_t;

  exp_t sbq[$];

  int vectors = 0;
  int misses  = 0;
  int cyc     = 0;

  logic [15:0] mw [2];

  always #5 gclk = ~gclk;

  always @(posedge gclk) cyc <= cyc + 1;

  tuss_spi_master #(.CLK_DIV(4), .AUTO_PARITY(1)) dut_a (
    .gclk(gclk), .rst(rst), .tx_en(tx_en[0]), .tx_data(tx_data[0]), .miso(miso[0]),
    .spi_data_out(spi_out[0]), .done(done[0]), .busy(busy[0]), .cs_n(cs_n[0]),
    .sclk(sclk[0]), .mosi(mosi[0])
  );

  tuss_spi_master #(.CLK_DIV(2), .AUTO_PARITY(0)) dut_b (
    .gclk(gclk), .rst(rst), .tx_en(tx_en[1]), .tx_data(tx_data[1]), .miso(miso[1]),
    .spi_data_out(spi_out[1]), .done(done[1]), .busy(busy[1]), .cs_n(cs_n[1]),
    .sclk(sclk[1]), .mosi(mosi[1])
  );

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s inst%0d: got %0h expected %0h at cycle %0d", name, inst, act, exp, cyc);
    end
  endtask

  // Reference: the word on mosi is tx_data, with bit 8 chosen so the frame has odd population.
  function automatic logic [15:0] model_mosi(input logic [15:0] d, input bit ap);
    logic [15:0] r;
    int ones;
    r = d;
    if (ap) begin
      ones = $countones(d & 16'hFEFF);
      r[8] = ((ones % 2) == 0);
    end
    return r;
  endfunction

  // Chip model: presents the next response bit after each sclk rising edge.
  int         rbit [2];
  logic [1:0] dsclk_p;
  logic [1:0] dcs_p;
  initial begin
    miso    = 2'b00;
    dsclk_p = 2'b00;
    dcs_p   = 2'b11;
    rbit[0] = 0;
    rbit[1] = 0;
    forever begin
      @(negedge gclk);
      for (int i = 0; i < 2; i++) begin
        if (dcs_p[i] && !cs_n[i]) rbit[i] = 0;
        if (!dsclk_p[i] && sclk[i]) begin
          if (rbit[i] < 16) miso[i] = mw[i][15 - rbit[i]];
          rbit[i]++;
        end
      end
      dsclk_p = sclk;
      dcs_p   = cs_n;
    end
  end

  // Monitor: checks bus timing against the frame start and pops the scoreboard on done.
  int          t0     [2];
  int          pulses [2];
  int          cs_hi  [2];
  logic [15:0] capw   [2];
  logic [15:0] held   [2];
  bit          infr   [2];
  logic [1:0]  msclk_p, mcs_p, mbusy_p, mmosi_p;
  always @(negedge gclk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        held[i]   = 16'h0000;
        cs_hi[i]  = 1000;
        infr[i]   = 1'b0;
        pulses[i] = 0;
        capw[i]   = 16'h0000;
        t0[i]     = 0;
      end
      msclk_p = 2'b00;
      mcs_p   = 2'b11;
      mbusy_p = 2'b00;
      mmosi_p = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit   ok;
        exp_t e;
        if (mcs_p[i] && !cs_n[i]) begin
          ok = (sbq.size() > 0) && (sbq[0].inst == i);
          chk("frame_expected", i, 32'(ok), 32'd1);
          chk("cs_gap_ok", i, 32'(cs_hi[i] >= dv[i]), 32'd1);
          t0[i]     = cyc;
          pulses[i] = 0;
          capw[i]   = 16'h0000;
          infr[i]   = 1'b1;
        end
        if (cs_n[i]) cs_hi[i]++;
        else cs_hi[i] = 0;
        if (infr[i] && !msclk_p[i] && sclk[i]) begin
          chk("rise_time", i, 32'(cyc - t0[i]), 32'((2 * pulses[i] + 1) * dv[i]));
          capw[i] = {capw[i][14:0], mosi[i]};
          pulses[i]++;
        end
        if (infr[i] && msclk_p[i] && !sclk[i]) begin
          chk("fall_time", i, 32'(cyc - t0[i]), 32'(2 * pulses[i] * dv[i]));
        end
        if (msclk_p[i] && sclk[i]) begin
          chk("mosi_stable", i, 32'(mosi[i]), 32'(mmosi_p[i]));
        end
        if (done[i]) begin
          ok = infr[i] && (sbq.size() > 0) && (sbq[0].inst == i);
          chk("done_expected", i, 32'(ok), 32'd1);
          if (ok) begin
            e = sbq.pop_front();
            chk("done_time", i, 32'(cyc - t0[i]), 32'(33 * dv[i]));
            chk("rx_word", i, 32'(spi_out[i]), 32'(e.rx));
            chk("mosi_word", i, 32'(capw[i]), 32'(e.mosi));
            chk("sclk_pulses", i, 32'(pulses[i]), 32'd16);
            chk("cs_high_at_done", i, 32'(cs_n[i]), 32'd1);
            held[i] = e.rx;
            infr[i] = 1'b0;
          end
        end else begin
          chk("data_hold", i, 32'(spi_out[i]), 32'(held[i]));
        end
        if (mbusy_p[i] && !busy[i]) begin
          chk("busy_time", i, 32'(cyc - t0[i]), 32'(34 * dv[i]));
        end
      end
      msclk_p = sclk;
      mcs_p   = cs_n;
      mbusy_p = busy;
      mmosi_p = mosi;
    end
  end

  // Issue a frame: tx_en low for one cycle, then high so the next rising gclk is the start edge.
  task automatic send(input int i, input logic [15:0] d, input logic [15:0] m);
    exp_t e;
    @(negedge gclk);
    tx_en[i]   = 1'b0;
    tx_data[i] = d;
    mw[i]      = m;
    @(negedge gclk);
    e.inst = i;
    e.mosi = model_mosi(d, apv[i]);
    e.rx   = m;
    sbq.push_back(e);
    tx_en[i] = 1'b1;
  endtask

  // Scramble tx_data after the start edge, then wait (bounded) for busy to fall.
  task automatic wait_idle(input int i);
    int n;
    @(negedge gclk);
    tx_data[i] = 16'($urandom);
    n = 0;
    while (busy[i] && n < 40 * dv[i] + 20) begin
      @(negedge gclk);
      n++;
    end
    chk("busy_timeout", i, 32'(busy[i]), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_cs_n"}, i, 32'(cs_n[i]), 32'd1);
      chk({tag, "_sclk"}, i, 32'(sclk[i]), 32'd0);
      chk({tag, "_mosi"}, i, 32'(mosi[i]), 32'd0);
      chk({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
      chk({tag, "_done"}, i, 32'(done[i]), 32'd0);
      chk({tag, "_data"}, i, 32'(spi_out[i]), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tx_en      = 2'b11;
    tx_data[0] = 16'h0000;
    tx_data[1] = 16'h0000;
    mw[0]      = 16'h0000;
    mw[1]      = 16'h0000;
    rst        = 1'b1;
    repeat (3) @(negedge gclk);
    chk_reset_outputs("por");
    rst = 1'b0;
    // tx_en held high through reset must not start a frame.
    repeat (20) @(negedge gclk);
    chk("no_start_after_por", 0, 32'(busy[0]), 32'd0);
    chk("no_start_after_por", 1, 32'(busy[1]), 32'd0);

    // Directed frames on the CLK_DIV=4 parity instance.
    send(0, 16'h2000, 16'h1234); wait_idle(0);
    send(0, 16'hB400, 16'hA5C3); wait_idle(0);

    // Second edge at E0+50 while busy: dropped.
    send(0, 16'($urandom), 16'($urandom));
    repeat (40) @(negedge gclk);
    tx_en[0] = 1'b0;
    repeat (10) @(negedge gclk);
    tx_en[0] = 1'b1;
    wait_idle(0);

    // Edge landing on the cycle busy falls: ignored.
    send(0, 16'($urandom), 16'($urandom));
    repeat (34 * 4 - 1) @(negedge gclk);
    tx_en[0] = 1'b0;
    @(negedge gclk);
    tx_en[0] = 1'b1;
    repeat (4) @(negedge gclk);
    chk("edge_at_busy_fall_ignored", 0, 32'(busy[0]), 32'd0);

    // Edge in the first IDLE cycle: accepted back-to-back.
    send(0, 16'($urandom), 16'($urandom));
    repeat (34 * 4 - 1) @(negedge gclk);
    send(0, 16'($urandom), 16'($urandom));
    wait_idle(0);

    for (int n = 0; n < 6; n++) begin
      send(0, 16'($urandom), 16'($urandom));
      wait_idle(0);
    end
    send(0, 16'h1357, 16'hA5C3); wait_idle(0);

    // Asynchronous reset during bit 7 of a frame.
    send(0, 16'h4321, 16'h0F0F);
    repeat (62) @(negedge gclk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    sbq.delete();
    repeat (3) @(negedge gclk);
    rst = 1'b0;
    repeat (50) @(negedge gclk);
    chk("no_start_after_rst", 0, 32'(busy[0]), 32'd0);
    chk("cs_idle_after_rst", 0, 32'(cs_n[0]), 32'd1);
    send(0, 16'h2000, 16'h5AA5); wait_idle(0);

    // Verbatim CLK_DIV=2 instance.
    send(1, 16'h2100, 16'hC33C); wait_idle(1);
    for (int n = 0; n < 6; n++) begin
      send(1, 16'($urandom), 16'($urandom));
      wait_idle(1);
    end

    repeat (5) @(negedge gclk);
    chk("scoreboard_drained", 0, 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
